// File: rtl/rpn_calc_pkg.sv
// Shared definitions for the RPN stack calculator: opcodes, error codes and
// the controller state encoding.
package rpn_calc_pkg;

    // Command opcodes; 10..15 are illegal
    localparam logic [3:0] OP_PUSH  = 4'd0;
    localparam logic [3:0] OP_POP   = 4'd1;
    localparam logic [3:0] OP_ADD   = 4'd2;
    localparam logic [3:0] OP_MUL   = 4'd3;
    localparam logic [3:0] OP_SUB   = 4'd4;
    localparam logic [3:0] OP_DIV   = 4'd5;
    localparam logic [3:0] OP_MOD   = 4'd6;
    localparam logic [3:0] OP_CLEAR = 4'd7;
    localparam logic [3:0] OP_DUP   = 4'd8;
    localparam logic [3:0] OP_SWAP  = 4'd9;

    // Sticky error codes; only the first error after a CLEAR/reset is kept
    localparam logic [2:0] ERR_NONE      = 3'd0;
    localparam logic [2:0] ERR_OVERFLOW  = 3'd1;
    localparam logic [2:0] ERR_UNDERFLOW = 3'd2;
    localparam logic [2:0] ERR_DIV_ZERO  = 3'd3;
    localparam logic [2:0] ERR_ILLEGAL   = 3'd4;

    // Controller state: IDLE accepts commands, DIV waits for the divider
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_DIV  = 1'b1
    } state_t;

endpackage

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per cycle.
// A start pulse loads the operands; WIDTH cycles later done is high for one
// cycle, and quotient/remainder are valid combinationally during that cycle
// so the caller can capture them on the same edge that ends the divide.
module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] quo_step;

    // One restoring step: shift in the next dividend bit, subtract if it fits
    always_comb begin
        shifted  = {rem_q, quo_q[WIDTH-1]};
        rem_step = shifted[WIDTH-1:0];
        quo_step = {quo_q[WIDTH-2:0], 1'b0};
        if (shifted >= {1'b0, dvs_q}) begin
            rem_step = WIDTH'(shifted - {1'b0, dvs_q});
            quo_step = {quo_q[WIDTH-2:0], 1'b1};
        end
        done      = busy_q && (cnt_q == CW'(1));
        quotient  = quo_step;
        remainder = rem_step;
    end

    // Next-state: load on start, otherwise iterate while busy
    always_comb begin
        rem_d  = rem_q;
        quo_d  = quo_q;
        dvs_d  = dvs_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (start) begin
            rem_d  = '0;
            quo_d  = dividend;
            dvs_d  = divisor;
            cnt_d  = CW'(WIDTH);
            busy_d = 1'b1;
        end else if (busy_q) begin
            rem_d = rem_step;
            quo_d = quo_step;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                busy_d = 1'b0;
            end
        end
    end

    // Divider registers; reset abandons any divide in flight
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dvs_q  <= dvs_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

endmodule

// File: rtl/rpn_stack_calc.sv
// RPN stack calculator: LIFO operand stack with push/pop, arithmetic,
// DUP/SWAP/CLEAR and a multi-cycle unsigned divide.
// Build option: define CALC_SATURATE_EN to make ADD/MUL clamp to all-ones
// and SUB clamp to zero instead of wrapping.
//
// Handshake: a command is taken on a rising edge where cmd_valid && cmd_ready;
// cmd_valid may be held across cycles where cmd_ready is low, and nothing
// changes on an edge without that pair. Outputs reflect a command after the
// accepting edge (DIV/MOD: after the edge that ends the busy window).
module rpn_stack_calc
    import rpn_calc_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] top,
    output logic             empty,
    output logic             full,
    output logic [CNT_W-1:0] count,
    output logic             err,
    output logic [2:0]       err_code,
    output state_t           dbg_state
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TWO  = CNT_W'(2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    // Entry 0 is the bottom of the stack; T lives at count-1, N at count-2
    logic [WIDTH-1:0] stack_q [DEPTH];
    logic [WIDTH-1:0] stack_d [DEPTH];
    logic [CNT_W-1:0] count_q, count_d;
    logic             err_q, err_d;
    logic [2:0]       err_code_q, err_code_d;
    state_t           state_q, state_d;
    logic             div_mod_q, div_mod_d;

    logic [IDX_W-1:0] idx_t, idx_n, idx_push;
    logic [WIDTH-1:0] opnd_t, opnd_n;
    logic [WIDTH-1:0] alu_res;
    logic [2:0]       cmd_err;

    logic             div_start;
    logic [WIDTH-1:0] div_quo, div_rem;
    logic             div_done;

`ifdef CALC_SATURATE_EN
    logic [WIDTH:0]     sum_w;
    logic [2*WIDTH-1:0] prod_w;
    assign sum_w  = {1'b0, opnd_t} + {1'b0, opnd_n};
    assign prod_w = {{WIDTH{1'b0}}, opnd_t} * {{WIDTH{1'b0}}, opnd_n};
`endif

    // Operand addressing; indices are only used when the count guards allow
    always_comb begin
        idx_t    = IDX_W'(count_q - CNT_ONE);
        idx_n    = IDX_W'(count_q - CNT_TWO);
        idx_push = IDX_W'(count_q);
        opnd_t   = stack_q[idx_t];
        opnd_n   = stack_q[idx_n];
    end

    // Single-cycle ALU: result = T op N
    always_comb begin
        alu_res = opnd_t;
        case (op)
`ifdef CALC_SATURATE_EN
            OP_ADD:  alu_res = sum_w[WIDTH] ? '1 : sum_w[WIDTH-1:0];
            OP_MUL:  alu_res = (|prod_w[2*WIDTH-1:WIDTH]) ? '1 : prod_w[WIDTH-1:0];
            OP_SUB:  alu_res = (opnd_n > opnd_t) ? '0 : opnd_t - opnd_n;
`else
            OP_ADD:  alu_res = opnd_t + opnd_n;
            OP_MUL:  alu_res = opnd_t * opnd_n;
            OP_SUB:  alu_res = opnd_t - opnd_n;
`endif
            default: alu_res = opnd_t;
        endcase
    end

    // Command decode, error checks and controller next-state
    always_comb begin
        stack_d    = stack_q;
        count_d    = count_q;
        err_d      = err_q;
        err_code_d = err_code_q;
        state_d    = state_q;
        div_mod_d  = div_mod_q;
        div_start  = 1'b0;
        cmd_err    = ERR_NONE;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (op == OP_CLEAR) begin
                        count_d    = '0;
                        err_d      = 1'b0;
                        err_code_d = ERR_NONE;
                    end else if (!err_q) begin
                        case (op)
                            OP_PUSH: begin
                                if (count_q == CNT_FULL) begin
                                    cmd_err = ERR_OVERFLOW;
                                end else begin
                                    stack_d[idx_push] = in_data;
                                    count_d = count_q + CNT_ONE;
                                end
                            end
                            OP_POP: begin
                                if (count_q == '0) begin
                                    cmd_err = ERR_UNDERFLOW;
                                end else begin
                                    count_d = count_q - CNT_ONE;
                                end
                            end
                            OP_ADD, OP_MUL, OP_SUB: begin
                                if (count_q < CNT_TWO) begin
                                    cmd_err = ERR_UNDERFLOW;
                                end else begin
                                    stack_d[idx_n] = alu_res;
                                    count_d = count_q - CNT_ONE;
                                end
                            end
                            OP_DIV, OP_MOD: begin
                                if (count_q < CNT_TWO) begin
                                    cmd_err = ERR_UNDERFLOW;
                                end else if (opnd_n == '0) begin
                                    cmd_err = ERR_DIV_ZERO;
                                end else begin
                                    div_start = 1'b1;
                                    div_mod_d = (op == OP_MOD);
                                    state_d   = ST_DIV;
                                end
                            end
                            OP_DUP: begin
                                if (count_q == CNT_FULL) begin
                                    cmd_err = ERR_OVERFLOW;
                                end else if (count_q == '0) begin
                                    cmd_err = ERR_UNDERFLOW;
                                end else begin
                                    stack_d[idx_push] = opnd_t;
                                    count_d = count_q + CNT_ONE;
                                end
                            end
                            OP_SWAP: begin
                                if (count_q < CNT_TWO) begin
                                    cmd_err = ERR_UNDERFLOW;
                                end else begin
                                    stack_d[idx_t] = opnd_n;
                                    stack_d[idx_n] = opnd_t;
                                end
                            end
                            default: cmd_err = ERR_ILLEGAL;
                        endcase
                        if (cmd_err != ERR_NONE) begin
                            err_d      = 1'b1;
                            err_code_d = cmd_err;
                        end
                    end
                end
            end
            ST_DIV: begin
                // Stack is frozen until the divider's last step commits
                if (div_done) begin
                    stack_d[idx_n] = div_mod_q ? div_rem : div_quo;
                    count_d        = count_q - CNT_ONE;
                    state_d        = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stack_q    <= '{default: '0};
            count_q    <= '0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
            state_q    <= ST_IDLE;
            div_mod_q  <= 1'b0;
        end else begin
            stack_q    <= stack_d;
            count_q    <= count_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            state_q    <= state_d;
            div_mod_q  <= div_mod_d;
        end
    end

    seq_divider #(
        .WIDTH (WIDTH)
    ) u_div (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (div_start),
        .dividend  (opnd_t),
        .divisor   (opnd_n),
        .quotient  (div_quo),
        .remainder (div_rem),
        .done      (div_done)
    );

    assign cmd_ready = (state_q == ST_IDLE);
    assign top       = (count_q == '0) ? '0 : opnd_t;
    assign empty     = (count_q == '0);
    assign full      = (count_q == CNT_FULL);
    assign count     = count_q;
    assign err       = err_q;
    assign err_code  = err_code_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_rpn_stack_calc.sv
// Testbench for rpn_stack_calc (WIDTH=8, DEPTH=8). Directed commands push
// their expected response into a queue; a monitor pops and compares each
// time the DUT finishes a command.
module tb_rpn_stack_calc;
    import rpn_calc_pkg::*;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;
    localparam int CNT_W = 4;

`ifdef CALC_SATURATE_EN
    localparam logic [7:0] EXP_ADD_OVF = 8'd255;
    localparam logic [7:0] EXP_SUB_NEG = 8'd0;
`else
    localparam logic [7:0] EXP_ADD_OVF = 8'd44;
    localparam logic [7:0] EXP_SUB_NEG = 8'd254;
`endif

    logic             clk;
    logic             reset_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] in_data;
    logic [WIDTH-1:0] top;
    logic             empty;
    logic             full;
    logic [CNT_W-1:0] count;
    logic             err;
    logic [2:0]       err_code;
    state_t           dbg_state;

    typedef struct {
        string      name;
        logic [7:0] top;
        int         cnt;
        logic       err;
        logic [2:0] code;
        int         busy;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad = 0;
    int   busy_cnt = 0;
    logic acc_q;

    rpn_stack_calc #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .op        (op),
        .in_data   (in_data),
        .top       (top),
        .empty     (empty),
        .full      (full),
        .count     (count),
        .err       (err),
        .err_code  (err_code),
        .dbg_state (dbg_state)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
        $fatal(1, "watchdog expired");
    end

    // Handshake observation
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) acc_q <= 1'b0;
        else          acc_q <= cmd_valid && cmd_ready;
    end

    // Monitor: a command has finished when cmd_ready is high after either an
    // accept or a busy window; measure the busy window length as well
    always @(negedge clk) begin
        if (!reset_n) begin
            busy_cnt = 0;
        end else if (!cmd_ready) begin
            busy_cnt++;
        end else if (acc_q || busy_cnt != 0) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_response: got top=%0d count=%0d err=%0d code=%0d, required no response",
                         top, count, err, err_code);
            end else begin
                mon_e = exp_q.pop_front();
                if (top !== mon_e.top || count !== CNT_W'(mon_e.cnt) || err !== mon_e.err ||
                    err_code !== mon_e.code || empty !== (mon_e.cnt == 0) ||
                    full !== (mon_e.cnt == DEPTH) || busy_cnt != mon_e.busy) begin
                    bad++;
                    $display("FAIL %s: got top=%0d count=%0d err=%0d code=%0d empty=%0d full=%0d busy=%0d, required top=%0d count=%0d err=%0d code=%0d empty=%0d full=%0d busy=%0d",
                             mon_e.name, top, count, err, err_code, empty, full, busy_cnt,
                             mon_e.top, mon_e.cnt, mon_e.err, mon_e.code,
                             (mon_e.cnt == 0), (mon_e.cnt == DEPTH), mon_e.busy);
                end
            end
            busy_cnt = 0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Driver: raise cmd_valid, hold it until cmd_ready, drop it after the accept
    task automatic send(input string name, input logic [3:0] o, input logic [7:0] d,
                        input logic [7:0] e_top, input int e_cnt, input logic e_err,
                        input logic [2:0] e_code, input int e_busy, input bit chk = 1'b1);
        exp_t e;
        int   waited;
        if (chk) begin
            e.name = name;
            e.top  = e_top;
            e.cnt  = e_cnt;
            e.err  = e_err;
            e.code = e_code;
            e.busy = e_busy;
            exp_q.push_back(e);
        end
        cmd_valid = 1'b1;
        op        = o;
        in_data   = d;
        waited    = 0;
        while (!cmd_ready && waited < 64) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (!cmd_ready) begin
            total++;
            bad++;
            $display("FAIL %s_ready_timeout: cmd_ready=0 after %0d cycles, required 1", name, waited);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 64) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d outstanding responses, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Reset asserted between clock edges; outputs must clear with no edge
    task automatic apply_reset(input string name);
        wait_drain();
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check({name, "_ready"}, 32'(cmd_ready), 32'd1);
        check({name, "_count"}, 32'(count), 32'd0);
        check({name, "_top"}, 32'(top), 32'd0);
        check({name, "_empty"}, 32'(empty), 32'd1);
        check({name, "_full"}, 32'(full), 32'd0);
        check({name, "_err"}, 32'(err), 32'd0);
        check({name, "_code"}, 32'(err_code), 32'(ERR_NONE));
        check({name, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
        @(negedge clk);
        #1;
        @(negedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        op        = '0;
        in_data   = '0;
        apply_reset("por");

        // Fill to DEPTH, then overflow
        for (int i = 1; i <= DEPTH; i++) begin
            send("push_fill", OP_PUSH, 8'd4, 8'd4, i, 1'b0, ERR_NONE, 0);
        end
        send("push_overflow", OP_PUSH, 8'd4, 8'd4, DEPTH, 1'b1, ERR_OVERFLOW, 0);
        apply_reset("rst_after_ovf");

        // Single-cycle arithmetic
        send("add_p1", OP_PUSH, 8'd4, 8'd4, 1, 1'b0, ERR_NONE, 0);
        send("add_p2", OP_PUSH, 8'd4, 8'd4, 2, 1'b0, ERR_NONE, 0);
        send("add_4_4", OP_ADD, 8'd0, 8'd8, 1, 1'b0, ERR_NONE, 0);
        send("clear1", OP_CLEAR, 8'd0, 8'd0, 0, 1'b0, ERR_NONE, 0);
        send("mul_p1", OP_PUSH, 8'd4, 8'd4, 1, 1'b0, ERR_NONE, 0);
        send("mul_p2", OP_PUSH, 8'd4, 8'd4, 2, 1'b0, ERR_NONE, 0);
        send("mul_4_4", OP_MUL, 8'd0, 8'd16, 1, 1'b0, ERR_NONE, 0);
        send("clear2", OP_CLEAR, 8'd0, 8'd0, 0, 1'b0, ERR_NONE, 0);
        send("sub_p1", OP_PUSH, 8'd4, 8'd4, 1, 1'b0, ERR_NONE, 0);
        send("sub_p2", OP_PUSH, 8'd4, 8'd4, 2, 1'b0, ERR_NONE, 0);
        send("sub_4_4", OP_SUB, 8'd0, 8'd0, 1, 1'b0, ERR_NONE, 0);
        send("clear3", OP_CLEAR, 8'd0, 8'd0, 0, 1'b0, ERR_NONE, 0);
        send("ovf_p1", OP_PUSH, 8'd200, 8'd200, 1, 1'b0, ERR_NONE, 0);
        send("ovf_p2", OP_PUSH, 8'd100, 8'd100, 2, 1'b0, ERR_NONE, 0);
        send("add_200_100", OP_ADD, 8'd0, EXP_ADD_OVF, 1, 1'b0, ERR_NONE, 0);
        send("clear4", OP_CLEAR, 8'd0, 8'd0, 0, 1'b0, ERR_NONE, 0);
        send("neg_p1", OP_PUSH, 8'd5, 8'd5, 1, 1'b0, ERR_NONE, 0);
        send("neg_p2", OP_PUSH, 8'd3, 8'd3, 2, 1'b0, ERR_NONE, 0);
        send("sub_3_5", OP_SUB, 8'd0, EXP_SUB_NEG, 1, 1'b0, ERR_NONE, 0);
        send("clear5", OP_CLEAR, 8'd0, 8'd0, 0, 1'b0, ERR_NONE, 0);

        // Multi-cycle divide; the PUSH after DIV is held through the busy window
        send("div_p1", OP_PUSH, 8'd7, 8'd7, 1, 1'b0, ERR_NONE, 0);
        send("div_p2", OP_PUSH, 8'd86, 8'd86, 2, 1'b0, ERR_NONE, 0);
        send("div_86_7", OP_DIV, 8'd0, 8'd12, 1, 1'b0, ERR_NONE, 8);
        send("push_held", OP_PUSH, 8'd9, 8'd9, 2, 1'b0, ERR_NONE, 0);
        send("clear6", OP_CLEAR, 8'd0, 8'd0, 0, 1'b0, ERR_NONE, 0);
        send("mod_p1", OP_PUSH, 8'd7, 8'd7, 1, 1'b0, ERR_NONE, 0);
        send("mod_p2", OP_PUSH, 8'd86, 8'd86, 2, 1'b0, ERR_NONE, 0);
        send("mod_86_7", OP_MOD, 8'd0, 8'd2, 1, 1'b0, ERR_NONE, 8);
        send("clear7", OP_CLEAR, 8'd0, 8'd0, 0, 1'b0, ERR_NONE, 0);

        // Divide by zero is caught at accept; error blocks until CLEAR
        send("dz_p1", OP_PUSH, 8'd0, 8'd0, 1, 1'b0, ERR_NONE, 0);
        send("dz_p2", OP_PUSH, 8'd86, 8'd86, 2, 1'b0, ERR_NONE, 0);
        send("div_by_zero", OP_DIV, 8'd0, 8'd86, 2, 1'b1, ERR_DIV_ZERO, 0);
        send("push_in_err", OP_PUSH, 8'd1, 8'd86, 2, 1'b1, ERR_DIV_ZERO, 0);
        send("clear_err", OP_CLEAR, 8'd0, 8'd0, 0, 1'b0, ERR_NONE, 0);

        // Underflow, first error kept, illegal opcode
        send("div_empty", OP_DIV, 8'd0, 8'd0, 0, 1'b1, ERR_UNDERFLOW, 0);
        send("illegal_sticky", 4'd12, 8'd0, 8'd0, 0, 1'b1, ERR_UNDERFLOW, 0);
        apply_reset("rst_before_ill");
        send("illegal_op", 4'd12, 8'd0, 8'd0, 0, 1'b1, ERR_ILLEGAL, 0);
        apply_reset("rst_after_ill");

        // DUP / SWAP / POP
        send("ds_p1", OP_PUSH, 8'd5, 8'd5, 1, 1'b0, ERR_NONE, 0);
        send("dup", OP_DUP, 8'd0, 8'd5, 2, 1'b0, ERR_NONE, 0);
        send("swap_same", OP_SWAP, 8'd0, 8'd5, 2, 1'b0, ERR_NONE, 0);
        send("ds_p2", OP_PUSH, 8'd9, 8'd9, 3, 1'b0, ERR_NONE, 0);
        send("swap", OP_SWAP, 8'd0, 8'd5, 3, 1'b0, ERR_NONE, 0);
        send("pop", OP_POP, 8'd0, 8'd9, 2, 1'b0, ERR_NONE, 0);

        // Reset in the middle of a divide aborts it
        apply_reset("rst_before_abort");
        send("ab_p1", OP_PUSH, 8'd7, 8'd7, 1, 1'b0, ERR_NONE, 0);
        send("ab_p2", OP_PUSH, 8'd86, 8'd86, 2, 1'b0, ERR_NONE, 0);
        send("ab_div", OP_DIV, 8'd0, 8'd0, 0, 1'b0, ERR_NONE, 0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("busy_mid_div", 32'(cmd_ready), 32'd0);
        apply_reset("rst_mid_div");
        send("push_after_abort", OP_PUSH, 8'd3, 8'd3, 1, 1'b0, ERR_NONE, 0);

        wait_drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rpn_stack_calc.md
Name: rpn_stack_calc

Overview:
Parametrised successor to the team's fixed 8-bit, 5-deep push/op calculator.
- LIFO operand stack of DEPTH words of WIDTH bits.
- Binary ops pop two operands and push one result.
- Adds a valid/ready command handshake, occupancy/full flags, an encoded sticky error, DUP/SWAP/CLEAR ops, and a multi-cycle sequential divider.
- Sits between the command source (bench or sequencer) and a result consumer reading top.

Parameters:
- WIDTH, 8, operand/result width in bits (>=2).
- DEPTH, 8, stack entries (>=2).
- CNT_W, $clog2(DEPTH+1), width of count output (derived; not overridden).

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command this cycle.
- op  in  4  opcode: 0 PUSH, 1 POP, 2 ADD, 3 MUL, 4 SUB, 5 DIV, 6 MOD, 7 CLEAR, 8 DUP, 9 SWAP, 10-15 illegal.
- in_data  in  WIDTH  PUSH operand.
- top  out  WIDTH  top-of-stack (most recently pushed); 0 when empty.
- empty  out  1  count==0.
- full  out  1  count==DEPTH.
- count  out  CNT_W  current occupancy.
- err  out  1  sticky error flag; the successor of the old valid, inverted.
- err_code  out  3  0 none, 1 overflow, 2 underflow, 3 div-by-zero, 4 illegal op; holds the first error.

Behaviour:
- Reset (async assert, sync-safe deassert): count=0, top=0, empty=1, full=0, err=0, err_code=0, cmd_ready=1, FSM=IDLE. Reset aborts any divide in flight.
- A command is accepted on a rising edge with cmd_valid&&cmd_ready. Outputs reflect the command after that edge.
- Notation: T=top, N=entry below top.
- Binary result = T op N, matching legacy operand order. Example: push 7, push 86, DIV -> 12.
- Binary ops replace T,N with the result; count-1.
- ADD/SUB/MUL: single cycle, wrap modulo 2^WIDTH; MUL keeps the low WIDTH bits.
- PUSH: count+1, top=in_data. POP: count-1. CLEAR: count=0; also clears err/err_code.
- DUP: pushes a copy of T. SWAP: exchanges T and N. Both single cycle.
- DIV/MOD (unsigned):
  - on accept, FSM IDLE->DIV and cmd_ready=0 for exactly WIDTH cycles;
  - on the final cycle the result is written and the FSM returns to IDLE;
  - cmd_ready=1 on the following cycle.
  - Stack and outputs are unchanged while in DIV.
- Errors are checked at accept:
  - PUSH/DUP when full -> overflow;
  - POP on empty, or binary/SWAP with count<2 -> underflow;
  - DIV/MOD with N==0 -> div-by-zero, detected at accept with no DIV cycles;
  - op>=10 -> illegal.
- An erroring command leaves the stack unchanged and sets err=1 and err_code (only if err was 0).
- While err=1: cmd_ready stays 1; every command except CLEAR is accepted and discarded. Only CLEAR or reset_n recovers.
- cmd_valid=0: no state change. op/in_data are don't-care when cmd_valid=0.

FSM states:
- IDLE -> DIV on an accepted, error-free DIV/MOD.
- DIV -> IDLE when the divider reports done.
- Error is a flag, not a state.

Optional Feature:
CALC_SATURATE_EN
- Defined: ADD and MUL clamp to 2^WIDTH-1 on overflow; SUB clamps to 0 when N>T. No error is raised.
- Undefined: wrap modulo 2^WIDTH as above.
- DIV/MOD are unaffected in both cases.

Decomposition:
- Package rpn_calc_pkg holds:
  - the opcode localparams (OP_PUSH..OP_SWAP);
  - the err_code localparams (ERR_NONE..ERR_ILLEGAL);
  - the FSM state encoding.
- Sub-module seq_divider (WIDTH-parametrised restoring divider):
  - inputs start, dividend, divisor;
  - outputs quotient, remainder, done;
  - done asserts after WIDTH cycles.

Test Plan:
- Reset, then PUSH 4 x DEPTH(8) -> count=8, full=1, err=0. 9th PUSH -> err=1, err_code=1, count stays 8. Pull reset_n low mid-cycle -> empty=1, err=0 immediately, with no clock edge needed.
- PUSH 4, PUSH 4, ADD -> top=8, count=1. Repeat with MUL -> 16, SUB -> 0. PUSH 200, PUSH 100, ADD -> 44 (wrap), or 255 with CALC_SATURATE_EN.
- PUSH 7, PUSH 86, DIV -> cmd_ready low for 8 cycles, then top=12, count=1. Same with MOD -> top=2. A command held on cmd_valid during the busy window is accepted only after cmd_ready rises.
- PUSH 0, PUSH 86, DIV -> err_code=3 on the next edge, no busy cycles, count=2. Subsequent PUSH is ignored. CLEAR -> err=0, empty=1.
- On empty stack: DIV -> err_code=2. Reset, then op=12 -> err_code=4. Reset, PUSH 5, DUP, SWAP -> count=2, top=5.
- Reset asserted during a DIV busy window -> cmd_ready=1, count=0, FSM IDLE. Next PUSH 3 -> top=3.
